rx_cda_align: RTL and testbench
===============================

# rx_cda_align

Link-training controller for the 30-channel LVDS receive path. Consumes the concatenated 40-bit per-channel words produced by the receive deserializer/demux stage. Drives that stage's per-channel data-realignment (bitslip) and realignment-reset controls, one channel at a time, until every channel presents a fixed training word. Asserts a ready flag once training completes; `O_fail_mask` identifies any channel that could not be aligned.

## Interface
Parameters:
- `NCH`, 30, number of LVDS channels.
- `W`, 40, demuxed word width per channel.
- `TRAIN_WORD`, 40'hF0F0_F0F0_F0, training pattern expected on every channel.
- `MAX_SLIPS`, 10, bitslip attempts per channel before declaring failure.
- `SETTLE_WORDS`, 4, valid words discarded after each reset/slip.
- `MATCH_WORDS`, 8, consecutive matching words required to pass a channel.

Ports:
- `I_clk`  in  1  — single clock; receive-word domain.
- `I_rst_n`  in  1  — asynchronous, active-low reset.
- `I_start`  in  1  — one-cycle pulse; starts or restarts training.
- `I_rx_locked`  in  1  — receiver PLL lock.
- `I_data`  in  NCH*W  — channel words; channel c occupies bits [c*W+W-1 : c*W].
- `I_data_vld`  in  1  — strobe; `I_data` holds a new word set this cycle.
- `O_rx_cda`  out  NCH  — per-channel bitslip pulse, one-hot or zero.
- `O_rx_cda_reset`  out  NCH  — per-channel realignment-counter reset pulse, one-hot or zero.
- `O_rx_cda_rdy`  out  1  — training complete with all channels aligned.
- `O_busy`  out  1  — training in progress.
- `O_fail_mask`  out  NCH  — bit c set if channel c failed.
- `O_cur_ch`  out  5  — channel currently under training.
- `O_word_phase`  out  2*NCH  — per-channel word rotation found (see Configuration).

## Operation
- States: IDLE, CRST, SETTLE, CHECK, SLIP, NEXT, DONE.
- IDLE/DONE: on `I_start`=1 with `I_rx_locked`=1, do the following and go to CRST:
  - clear `O_fail_mask` and `O_word_phase`;
  - set ch=0;
  - clear `O_rx_cda_rdy`.
- `I_start` while `I_rx_locked`=0 is ignored.
- CRST: drive `O_rx_cda_reset[ch]`=1 for exactly one cycle, clear slip_cnt, then go to SETTLE.
- SETTLE: count `I_data_vld` strobes. After `SETTLE_WORDS` strobes, clear match_cnt and go to CHECK.
- CHECK: evaluate word ch on each `I_data_vld`:
  - Match: increment match_cnt. When match_cnt reaches `MATCH_WORDS`, go to NEXT (channel passes).
  - Mismatch with slip_cnt < `MAX_SLIPS`: go to SLIP.
  - Mismatch with slip_cnt = `MAX_SLIPS`: set `O_fail_mask[ch]`, go to NEXT.
- SLIP: drive `O_rx_cda[ch]`=1 for exactly one cycle, increment slip_cnt, go to SETTLE.
- NEXT: if ch = NCH-1, go to DONE; otherwise increment ch and go to CRST.
- DONE: `O_rx_cda_rdy` = (`O_fail_mask` == 0). Hold until the next `I_start`.
- Loss of lock: `I_rx_locked`=0 in any state other than IDLE forces IDLE on the next cycle:
  - `O_rx_cda_rdy` and `O_busy` clear;
  - `O_fail_mask` retains its value.
- `I_start` during a training run (`O_busy`=1) restarts the run from ch=0 via CRST.
- Simultaneous `I_start` and `I_rx_locked` falling: loss of lock wins → IDLE.
- Counter widths are sized to hold their maximum count; no counter wraps.

## Timing
- All outputs are registered.
- Reset values:
  - `O_rx_cda`=0, `O_rx_cda_reset`=0, `O_rx_cda_rdy`=0, `O_busy`=0;
  - `O_fail_mask`=0, `O_cur_ch`=0, `O_word_phase`=0;
  - state = IDLE.
- `O_busy` is 1 in every state except IDLE and DONE. It rises in the cycle after the accepted `I_start`.
- `O_rx_cda_reset[ch]` is high in the cycle after entering CRST.
- `O_rx_cda[ch]` is high in the cycle after entering SLIP. Never more than one bit of `O_rx_cda | O_rx_cda_reset` is set.
- CHECK acts only on cycles with `I_data_vld`=1. Cycles with `I_data_vld`=0 neither advance nor reset any count.
- Best-case per channel: 1 (CRST) + `SETTLE_WORDS` + `MATCH_WORDS` valid words + 1 (NEXT).
- `O_rx_cda_rdy` rises one cycle after entering DONE.

## Configuration
- `RX_CDA_ROTATE_MATCH_EN` defined:
  - CHECK also accepts `TRAIN_WORD` rotated left by 10, 20 or 30 bits, covering the 10→40 demux phase ambiguity.
  - The first matching rotation is latched (0..3) into `O_word_phase[2c+1:2c]`.
  - Subsequent words must match that same rotation; a word matching a different rotation counts as a mismatch.
- Undefined: only the exact `TRAIN_WORD` matches, and `O_word_phase` stays 0.

## Test plan
- Reset, then all channels carry `TRAIN_WORD` from the start, and `I_start` is pulsed → no `O_rx_cda` pulses, 30 `O_rx_cda_reset` pulses in channel order 0..29, `O_rx_cda_rdy`=1, `O_fail_mask`=0.
- Channel 5 carries the training word misaligned by 3 slips (model applies a rotation per slip) → exactly 3 `O_rx_cda[5]` pulses, then `O_rx_cda_rdy`=1.
- Channel 12 is held at 40'h0 → 10 slips on channel 12, `O_fail_mask`=1<<12, `O_rx_cda_rdy`=0, training continues through channel 29.
- Drop `I_rx_locked` while channel 7 is in CHECK → IDLE the next cycle, `O_busy`=0. A later `I_start` with lock restarts at ch=0.
- `I_data_vld` low for 20 cycles mid-CHECK → match count is held, and completion resumes once strobes return.
- With `RX_CDA_ROTATE_MATCH_EN`: channel 3 carries `TRAIN_WORD` rotated by 20 bits → zero slips and `O_word_phase[7:6]`=2'd2.

Source files
------------

// File: rtl/rx_cda_align_if.sv
// Link between the deserializer/demux stage and the CDA alignment controller:
// demuxed channel words with their strobe, and the per-channel bitslip/reset pulses.
interface rx_cda_align_if #(
  parameter int NCH = 30,
  parameter int W   = 40
);
  logic [NCH*W-1:0] I_data;
  logic             I_data_vld;
  logic [NCH-1:0]   O_rx_cda;
  logic [NCH-1:0]   O_rx_cda_reset;

  modport master (output I_data, output I_data_vld, input O_rx_cda, input O_rx_cda_reset);
  modport slave  (input I_data, input I_data_vld, output O_rx_cda, output O_rx_cda_reset);
endinterface

// File: rtl/rx_cda_align.sv
// LVDS receive link-training controller: walks the channels one at a time, bitslipping until
// each presents TRAIN_WORD. Optional RX_CDA_ROTATE_MATCH_EN also accepts 10/20/30-bit word rotations.
module rx_cda_align #(
  parameter int             NCH          = 30,
  parameter int             W            = 40,
  parameter logic [W-1:0]   TRAIN_WORD   = 40'hF0F0_F0F0_F0,
  parameter int             MAX_SLIPS    = 10,
  parameter int             SETTLE_WORDS = 4,
  parameter int             MATCH_WORDS  = 8
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_start,
  input  logic             I_rx_locked,
  rx_cda_align_if.slave    lnk,
  output logic             O_rx_cda_rdy,
  output logic             O_busy,
  output logic [NCH-1:0]   O_fail_mask,
  output logic [4:0]       O_cur_ch,
  output logic [2*NCH-1:0] O_word_phase
);

  localparam int SLW = $clog2(MAX_SLIPS + 1);
  localparam int SEW = $clog2(SETTLE_WORDS + 1);
  localparam int MCW = $clog2(MATCH_WORDS + 1);
  localparam logic [SLW-1:0] SLIP_MAX    = SLW'(MAX_SLIPS);
  localparam logic [SEW-1:0] SETTLE_LAST = SEW'(SETTLE_WORDS - 1);
  localparam logic [MCW-1:0] MATCH_LAST  = MCW'(MATCH_WORDS - 1);
  localparam logic [4:0]     CH_LAST     = 5'(NCH - 1);
  localparam logic [NCH-1:0] CH_ONE      = NCH'(1);

  typedef enum logic [2:0] {IDLE, CRST, SETTLE, CHECK, SLIP, NEXT, DONE} state_t;

  state_t         state, state_nxt;
  logic [4:0]     ch;
  logic [SLW-1:0] slip_cnt;
  logic [SEW-1:0] settle_cnt;
  logic [MCW-1:0] match_cnt;
  logic [W-1:0]   word_cur;
  logic           hit;
  logic           start_acc;

  assign start_acc = I_start && I_rx_locked;
  assign word_cur  = lnk.I_data[int'(ch)*W +: W];
  assign O_cur_ch  = ch;

`ifdef RX_CDA_ROTATE_MATCH_EN
  logic           phase_lk;
  logic [1:0]     hit_rot;
  logic [1:0]     phase_cur;
  logic [2*NCH-1:0] word_phase;

  function automatic logic [W-1:0] rot_word(input logic [1:0] k);
    logic [2*W-1:0] t;
    t = {TRAIN_WORD, TRAIN_WORD} << (int'(k) * (W/4));
    return t[2*W-1:W];
  endfunction

  assign phase_cur    = word_phase[2*int'(ch) +: 2];
  assign O_word_phase = word_phase;

  // Once a rotation has been seen on this channel, only that rotation keeps counting.
  always_comb begin
    hit     = 1'b0;
    hit_rot = phase_cur;
    if (phase_lk) begin
      hit = (word_cur == rot_word(phase_cur));
    end else begin
      for (int k = 3; k >= 0; k--) begin
        if (word_cur == rot_word(2'(k))) begin
          hit     = 1'b1;
          hit_rot = 2'(k);
        end
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      phase_lk   <= 1'b0;
      word_phase <= '0;
    end else if (start_acc) begin
      phase_lk   <= 1'b0;
      word_phase <= '0;
    end else if (I_rx_locked) begin
      case (state)
        CRST, SLIP: phase_lk <= 1'b0;
        CHECK: begin
          if (lnk.I_data_vld && hit && !phase_lk) begin
            phase_lk                        <= 1'b1;
            word_phase[2*int'(ch) +: 2]     <= hit_rot;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign hit          = (word_cur == TRAIN_WORD);
  assign O_word_phase = '0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start_acc) state_nxt = CRST;
      CRST:   state_nxt = SETTLE;
      SETTLE: if (lnk.I_data_vld && settle_cnt == SETTLE_LAST) state_nxt = CHECK;
      CHECK: begin
        if (lnk.I_data_vld) begin
          if (hit) begin
            if (match_cnt == MATCH_LAST) state_nxt = NEXT;
          end else if (slip_cnt < SLIP_MAX) begin
            state_nxt = SLIP;
          end else begin
            state_nxt = NEXT;
          end
        end
      end
      SLIP:   state_nxt = SETTLE;
      NEXT:   state_nxt = (ch == CH_LAST) ? DONE : CRST;
      DONE:   if (start_acc) state_nxt = CRST;
      default: state_nxt = IDLE;
    endcase
    // Restart from any state; loss of lock overrides everything.
    if (start_acc) state_nxt = CRST;
    if (!I_rx_locked && state != IDLE) state_nxt = IDLE;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state              <= IDLE;
      ch                 <= '0;
      slip_cnt           <= '0;
      settle_cnt         <= '0;
      match_cnt          <= '0;
      O_fail_mask        <= '0;
      O_rx_cda_rdy       <= 1'b0;
      O_busy             <= 1'b0;
      lnk.O_rx_cda       <= '0;
      lnk.O_rx_cda_reset <= '0;
    end else begin
      state              <= state_nxt;
      O_busy             <= (state_nxt != IDLE) && (state_nxt != DONE);
      O_rx_cda_rdy       <= (state == DONE) && (state_nxt == DONE) && (O_fail_mask == '0);
      lnk.O_rx_cda       <= (state == SLIP && state_nxt == SETTLE) ? (CH_ONE << ch) : '0;
      lnk.O_rx_cda_reset <= (state == CRST && state_nxt == SETTLE) ? (CH_ONE << ch) : '0;

      if (start_acc) begin
        ch          <= '0;
        O_fail_mask <= '0;
      end else if (I_rx_locked) begin
        case (state)
          CRST: begin
            slip_cnt   <= '0;
            settle_cnt <= '0;
          end
          SETTLE: begin
            if (lnk.I_data_vld) begin
              if (settle_cnt == SETTLE_LAST) begin
                settle_cnt <= '0;
                match_cnt  <= '0;
              end else begin
                settle_cnt <= settle_cnt + 1'b1;
              end
            end
          end
          CHECK: begin
            if (lnk.I_data_vld) begin
              if (hit) match_cnt <= match_cnt + 1'b1;
              else if (slip_cnt == SLIP_MAX) O_fail_mask[ch] <= 1'b1;
            end
          end
          SLIP: begin
            slip_cnt   <= slip_cnt + 1'b1;
            settle_cnt <= '0;
          end
          NEXT: if (ch != CH_LAST) ch <= ch + 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_cda_align.sv
// Directed bench for rx_cda_align: a deserializer model rotates each channel's word by one
// bit per observed bitslip; scenarios cover alignment, slipping, failure, lock loss and strobe gaps.
module tb_rx_cda_align;
  localparam int NCH = 30;
  localparam int W   = 40;
  localparam logic [W-1:0] TW = 40'hF0F0_F0F0_F0;

  logic             I_clk = 1'b0;
  logic             I_rst_n;
  logic             I_start;
  logic             I_rx_locked;
  logic             O_rx_cda_rdy;
  logic             O_busy;
  logic [NCH-1:0]   O_fail_mask;
  logic [4:0]       O_cur_ch;
  logic [2*NCH-1:0] O_word_phase;

  always #5 I_clk = ~I_clk;

  rx_cda_align_if #(.NCH(NCH), .W(W)) lnk ();

  rx_cda_align #(.NCH(NCH), .W(W), .TRAIN_WORD(TW)) dut (
    .I_clk        (I_clk),
    .I_rst_n      (I_rst_n),
    .I_start      (I_start),
    .I_rx_locked  (I_rx_locked),
    .lnk          (lnk.slave),
    .O_rx_cda_rdy (O_rx_cda_rdy),
    .O_busy       (O_busy),
    .O_fail_mask  (O_fail_mask),
    .O_cur_ch     (O_cur_ch),
    .O_word_phase (O_word_phase)
  );

  int slips[NCH];
  int rot_off[NCH];
  bit zero_ch[NCH];
  int cda_cnt[NCH];
  int cda_tot, rst_cnt, exp_rst, rst_bad, hot_bad;
  bit drv_start, drv_lock, drv_gap;
  int n_chk, n_err;
  int n;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int s);
    logic [2*W-1:0] t;
    t = {x, x} << s;
    return t[2*W-1:W];
  endfunction

  task automatic clear_model();
    for (int c = 0; c < NCH; c++) begin
      slips[c] = 0; rot_off[c] = 0; zero_ch[c] = 1'b0; cda_cnt[c] = 0;
    end
    cda_tot = 0; rst_cnt = 0; exp_rst = 0; rst_bad = 0;
  endtask

  // Drive inputs for the coming rising edge, then observe outputs on the falling edge.
  task automatic tick();
    I_start        = drv_start;
    drv_start      = 1'b0;
    I_rx_locked    = drv_lock;
    lnk.I_data_vld = !drv_gap;
    for (int c = 0; c < NCH; c++)
      lnk.I_data[c*W +: W] = zero_ch[c] ? '0 : rotl(TW, (((rot_off[c] - slips[c]) % W) + W) % W);
    @(negedge I_clk);
    for (int c = 0; c < NCH; c++) begin
      if (lnk.O_rx_cda[c]) begin slips[c]++; cda_cnt[c]++; cda_tot++; end
      if (lnk.O_rx_cda_reset[c]) begin
        if (c != exp_rst) rst_bad++;
        exp_rst++; rst_cnt++;
      end
    end
    if ($countones({lnk.O_rx_cda, lnk.O_rx_cda_reset}) > 1) hot_bad++;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (O_busy && k < 4000) begin tick(); k++; end
    chk("train_done", 64'(O_busy), 64'd0);
    chk("rdy_latency", 64'(O_rx_cda_rdy), 64'd0);
    tick();
  endtask

  task automatic run_train();
    drv_start = 1'b1;
    tick();
    wait_done();
  endtask

  task automatic wait_rst_pulses(input int target);
    int k;
    k = 0;
    while (rst_cnt < target && k < 4000) begin tick(); k++; end
    chk("reach_channel", 64'(rst_cnt), 64'(target));
  endtask

  initial begin
    n_chk = 0; n_err = 0; hot_bad = 0;
    I_rst_n = 1'b0; drv_start = 1'b0; drv_lock = 1'b0; drv_gap = 1'b0;
    clear_model();
    repeat (3) tick();
    chk("rst_rdy", 64'(O_rx_cda_rdy), 64'd0);
    chk("rst_busy", 64'(O_busy), 64'd0);
    chk("rst_fail", 64'(O_fail_mask), 64'd0);
    chk("rst_cur_ch", 64'(O_cur_ch), 64'd0);
    chk("rst_cda", 64'(lnk.O_rx_cda), 64'd0);
    chk("rst_cda_reset", 64'(lnk.O_rx_cda_reset), 64'd0);
    chk("rst_phase", 64'(O_word_phase), 64'd0);
    I_rst_n = 1'b1;
    tick();

    drv_start = 1'b1;
    repeat (4) tick();
    chk("start_unlocked_busy", 64'(O_busy), 64'd0);
    chk("start_unlocked_pulses", 64'(rst_cnt), 64'd0);
    drv_lock = 1'b1;
    tick();

    clear_model();
    run_train();
    chk("aligned_cda_pulses", 64'(cda_tot), 64'd0);
    chk("aligned_rst_pulses", 64'(rst_cnt), 64'd30);
    chk("aligned_rst_order", 64'(rst_bad), 64'd0);
    chk("aligned_rdy", 64'(O_rx_cda_rdy), 64'd1);
    chk("aligned_fail", 64'(O_fail_mask), 64'd0);
    chk("aligned_last_ch", 64'(O_cur_ch), 64'd29);

    clear_model();
    rot_off[5] = 3;
    run_train();
`ifdef RX_CDA_ROTATE_MATCH_EN
    chk("ch5_slips", 64'(cda_cnt[5]), 64'd1);
    chk("ch5_total_slips", 64'(cda_tot), 64'd1);
    chk("ch5_phase", 64'(O_word_phase), 64'd1 << 10);
`else
    chk("ch5_slips", 64'(cda_cnt[5]), 64'd3);
    chk("ch5_total_slips", 64'(cda_tot), 64'd3);
    chk("ch5_phase_zero", 64'(O_word_phase), 64'd0);
`endif
    chk("ch5_rdy", 64'(O_rx_cda_rdy), 64'd1);
    chk("ch5_fail", 64'(O_fail_mask), 64'd0);

    clear_model();
    zero_ch[12] = 1'b1;
    run_train();
    chk("ch12_slips", 64'(cda_cnt[12]), 64'd10);
    chk("ch12_total_slips", 64'(cda_tot), 64'd10);
    chk("ch12_fail_mask", 64'(O_fail_mask), 64'd1 << 12);
    chk("ch12_rdy", 64'(O_rx_cda_rdy), 64'd0);
    chk("ch12_last_ch", 64'(O_cur_ch), 64'd29);
    chk("ch12_rst_pulses", 64'(rst_cnt), 64'd30);

    // Lock drop two matches into channel 7's check window; channel 2 failed earlier.
    clear_model();
    zero_ch[2] = 1'b1;
    drv_start = 1'b1;
    tick();
    wait_rst_pulses(8);
    chk("drop_cur_ch", 64'(O_cur_ch), 64'd7);
    repeat (6) tick();
    drv_lock = 1'b0;
    tick();
    chk("drop_busy", 64'(O_busy), 64'd0);
    chk("drop_rdy", 64'(O_rx_cda_rdy), 64'd0);
    chk("drop_fail_kept", 64'(O_fail_mask), 64'd1 << 2);
    repeat (5) tick();
    chk("drop_stays_idle", 64'(O_busy), 64'd0);
    drv_lock = 1'b1;
    tick();
    clear_model();
    drv_start = 1'b1;
    tick();
    chk("restart_ch", 64'(O_cur_ch), 64'd0);
    chk("restart_busy", 64'(O_busy), 64'd1);
    wait_done();
    chk("restart_rst_order", 64'(rst_bad), 64'd0);
    chk("restart_rst_pulses", 64'(rst_cnt), 64'd30);
    chk("restart_rdy", 64'(O_rx_cda_rdy), 64'd1);
    chk("restart_fail", 64'(O_fail_mask), 64'd0);

    // Strobe gap after four matches on channel 10: four more words must finish it.
    clear_model();
    drv_start = 1'b1;
    tick();
    wait_rst_pulses(11);
    repeat (8) tick();
    drv_gap = 1'b1;
    repeat (20) tick();
    chk("gap_hold_ch", 64'(O_cur_ch), 64'd10);
    chk("gap_hold_busy", 64'(O_busy), 64'd1);
    chk("gap_no_slips", 64'(cda_tot), 64'd0);
    drv_gap = 1'b0;
    n = 0;
    while (O_cur_ch != 5'd11 && n < 50) begin tick(); n++; end
    chk("gap_resume_words", 64'(n), 64'd5);
    wait_done();
    chk("gap_rdy", 64'(O_rx_cda_rdy), 64'd1);
    chk("gap_total_slips", 64'(cda_tot), 64'd0);

`ifdef RX_CDA_ROTATE_MATCH_EN
    clear_model();
    rot_off[3] = 20;
    run_train();
    chk("rot3_slips", 64'(cda_tot), 64'd0);
    chk("rot3_phase", 64'(O_word_phase), 64'd2 << 6);
    chk("rot3_rdy", 64'(O_rx_cda_rdy), 64'd1);
`endif

    chk("onehot_pulses", 64'(hot_bad), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
